// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and helpers for the header/body stream joiner
// Contents:
//   joiner_state_t : HEAD (forwarding header stream) / BODY (forwarding body stream)
//   ctr_width()    : header word counter width, max(1, $clog2(header_words+1))
// The joined word struct depends on module parameters, so each user declares it locally.
package axis_pkg;

    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } joiner_state_t;

    function automatic int ctr_width(input int header_words);
        int w;
        w = $clog2(header_words + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry register slice with registered input ready
// Ports:
//   clk, areset           : clock, asynchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready is a flop, no path from out_ready)
//   in_data [WIDTH]       : upstream word
//   out_valid/out_ready   : downstream handshake (out_valid/out_data are flops)
//   out_data [WIDTH]      : downstream word
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire;
    logic             out_free;
    logic             skid_next;

    assign in_fire  = in_valid & in_ready;
    assign out_free = out_ready | ~out_valid;
    // The skid entry is only ever filled while the output register is stalled;
    // input ready for the next cycle is simply "skid entry will be empty".
    assign skid_next = out_free ? 1'b0 : (skid_valid | in_fire);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            if (out_free) begin
                if (skid_valid) begin
                    // in_ready was low this cycle, so no new word can collide here
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= in_fire;
                    if (in_fire) begin
                        out_data <= in_data;
                    end
                end
            end else if (in_fire) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
            in_ready <= ~skid_next;
        end
    end

endmodule

// File: rtl/axis_joiner.sv
// rtl/axis_joiner.sv - joins one header packet (axis_i1) and one body packet (axis_i2) into axis_o
// Ports:
//   clk, areset                          : clock, asynchronous active-high reset
//   axis_i1_* (tvalid/tready/tdata/tkeep/tuser/tlast) : header stream
//   axis_i2_* (tvalid/tready/tdata/tkeep/tuser/tlast) : body stream, tlast ends the joined packet
//   axis_o_*  (tvalid/tready/tdata/tkeep/tuser/tlast) : joined stream, registered
//   hdr_err                              : 1-cycle pulse, header tlast disagrees with HEADER_WORDS framing
module axis_joiner
    import axis_pkg::*;
#(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int HEADER_WORDS   = 0
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic                      axis_i1_tvalid,
    output logic                      axis_i1_tready,
    input  logic [AXIS_BYTES*8-1:0]   axis_i1_tdata,
    input  logic [AXIS_BYTES-1:0]     axis_i1_tkeep,
    input  logic [AXIS_USER_BITS-1:0] axis_i1_tuser,
    input  logic                      axis_i1_tlast,
    input  logic                      axis_i2_tvalid,
    output logic                      axis_i2_tready,
    input  logic [AXIS_BYTES*8-1:0]   axis_i2_tdata,
    input  logic [AXIS_BYTES-1:0]     axis_i2_tkeep,
    input  logic [AXIS_USER_BITS-1:0] axis_i2_tuser,
    input  logic                      axis_i2_tlast,
    output logic                      axis_o_tvalid,
    input  logic                      axis_o_tready,
    output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
    output logic [AXIS_BYTES-1:0]     axis_o_tkeep,
    output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
    output logic                      axis_o_tlast,
    output logic                      hdr_err
);

    typedef struct packed {
        logic [AXIS_BYTES*8-1:0]   tdata;
        logic [AXIS_BYTES-1:0]     tkeep;
        logic [AXIS_USER_BITS-1:0] tuser;
        logic                      tlast;
    } axis_word_t;

    localparam int CW = ctr_width(HEADER_WORDS);
    localparam logic [CW-1:0] LAST_IDX = (HEADER_WORDS > 0) ? CW'(HEADER_WORDS - 1) : '0;

    joiner_state_t state_q, state_d;
    logic [CW-1:0] ctr_q;
    logic          slice_ready;
    logic          slice_valid;
    axis_word_t    slice_word;
    axis_word_t    out_word;
    logic          i1_fire;
    logic          i2_fire;
    logic          at_last_idx;
    logic          hdr_end;

    assign i1_fire     = axis_i1_tvalid & axis_i1_tready;
    assign i2_fire     = axis_i2_tvalid & axis_i2_tready;
    assign at_last_idx = (ctr_q == LAST_IDX);
    // With a fixed header length the counter alone frames the header; i1 tlast is only checked.
    assign hdr_end     = (HEADER_WORDS == 0) ? axis_i1_tlast : at_last_idx;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= HEAD;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (HEADER_WORDS > 0 && i1_fire) begin
                ctr_q <= hdr_end ? '0 : ctr_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HEAD:    if (i1_fire && hdr_end) state_d = BODY;
            BODY:    if (i2_fire && axis_i2_tlast) state_d = HEAD;
            default: state_d = HEAD;
        endcase
    end

    always_comb begin
        axis_i1_tready = 1'b0;
        axis_i2_tready = 1'b0;
        slice_valid    = 1'b0;
        slice_word     = '0;
        hdr_err        = 1'b0;
        case (state_q)
            HEAD: begin
                axis_i1_tready   = slice_ready;
                slice_valid      = axis_i1_tvalid;
                slice_word.tdata = axis_i1_tdata;
                slice_word.tkeep = axis_i1_tkeep;
                slice_word.tuser = axis_i1_tuser;
                slice_word.tlast = 1'b0;
                hdr_err = (HEADER_WORDS > 0) && axis_i1_tvalid && slice_ready
                          && (axis_i1_tlast != at_last_idx);
            end
            BODY: begin
                axis_i2_tready   = slice_ready;
                slice_valid      = axis_i2_tvalid;
                slice_word.tdata = axis_i2_tdata;
                slice_word.tkeep = axis_i2_tkeep;
                slice_word.tuser = axis_i2_tuser;
                slice_word.tlast = axis_i2_tlast;
            end
            default: ;
        endcase
    end

    axis_skid_buffer #(
        .WIDTH($bits(axis_word_t))
    ) u_slice (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (slice_valid),
        .in_ready  (slice_ready),
        .in_data   (slice_word),
        .out_valid (axis_o_tvalid),
        .out_ready (axis_o_tready),
        .out_data  (out_word)
    );

    assign axis_o_tdata = out_word.tdata;
    assign axis_o_tkeep = out_word.tkeep;
    assign axis_o_tuser = out_word.tuser;
    assign axis_o_tlast = out_word.tlast;

endmodule

// File: tb/tb_axis_joiner.sv
// tb/tb_axis_joiner.sv - directed self-checking bench for axis_joiner (HEADER_WORDS 0, 2 and 1)
module tb_axis_joiner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       areset;
    logic       i1_valid [3];
    logic       i1_ready [3];
    logic [7:0] i1_data  [3];
    logic       i1_keep  [3];
    logic       i1_user  [3];
    logic       i1_last  [3];
    logic       i2_valid [3];
    logic       i2_ready [3];
    logic [7:0] i2_data  [3];
    logic       i2_keep  [3];
    logic       i2_user  [3];
    logic       i2_last  [3];
    logic       o_valid  [3];
    logic       o_ready  [3];
    logic [7:0] o_data   [3];
    logic       o_keep   [3];
    logic       o_user   [3];
    logic       o_last   [3];
    logic       hdr_err  [3];
    logic [10:0] ow      [3];
    logic       rdy_set  [3];
    logic       stall_mode;
    logic       rnd = 1'b1;

    int checks = 0;
    int errors = 0;

    // monitor state
    logic [10:0] oq [3][$];
    int          oc [3][$];
    int          cyc = 0;
    int          err_cnt [3] = '{0, 0, 0};
    logic [7:0]  err_word [3] = '{8'h00, 8'h00, 8'h00};
    int          stall_bad = 0;
    logic        stalled [3] = '{1'b0, 1'b0, 1'b0};
    logic [10:0] held [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int HW = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        assign o_ready[g] = (g == 0 && stall_mode) ? rnd : rdy_set[g];
        assign ow[g] = {o_last[g], o_user[g], o_keep[g], o_data[g]};
        axis_joiner #(
            .AXIS_BYTES    (1),
            .AXIS_USER_BITS(1),
            .HEADER_WORDS  (HW)
        ) u_dut (
            .clk           (clk),
            .areset        (areset),
            .axis_i1_tvalid(i1_valid[g]),
            .axis_i1_tready(i1_ready[g]),
            .axis_i1_tdata (i1_data[g]),
            .axis_i1_tkeep (i1_keep[g]),
            .axis_i1_tuser (i1_user[g]),
            .axis_i1_tlast (i1_last[g]),
            .axis_i2_tvalid(i2_valid[g]),
            .axis_i2_tready(i2_ready[g]),
            .axis_i2_tdata (i2_data[g]),
            .axis_i2_tkeep (i2_keep[g]),
            .axis_i2_tuser (i2_user[g]),
            .axis_i2_tlast (i2_last[g]),
            .axis_o_tvalid (o_valid[g]),
            .axis_o_tready (o_ready[g]),
            .axis_o_tdata  (o_data[g]),
            .axis_o_tkeep  (o_keep[g]),
            .axis_o_tuser  (o_user[g]),
            .axis_o_tlast  (o_last[g]),
            .hdr_err       (hdr_err[g])
        );
    end

    always @(posedge clk) begin
        #1 rnd = ($urandom_range(0, 9) >= 3);
    end

    // Inputs change only at posedge+1, so negedge values describe the handshake at the next posedge.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (areset) begin
                stalled[k] = 1'b0;
            end else begin
                if (stalled[k] && (!o_valid[k] || ow[k] !== held[k])) stall_bad++;
                if (o_valid[k] && o_ready[k]) begin
                    oq[k].push_back(ow[k]);
                    oc[k].push_back(cyc);
                end
                stalled[k] = o_valid[k] && !o_ready[k];
                held[k]    = ow[k];
                if (hdr_err[k]) begin
                    err_cnt[k]++;
                    err_word[k] = i1_data[k];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] w(input logic last, input logic user, input logic keep,
                                      input logic [7:0] d);
        return {last, user, keep, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and returns just after the edge on which it was accepted; valid stays high.
    task automatic push(input int k, input bit hdr, input logic [7:0] d, input logic kp,
                        input logic us, input logic last);
        int n;
        if (hdr) begin
            i1_valid[k] = 1'b1; i1_data[k] = d; i1_keep[k] = kp; i1_user[k] = us; i1_last[k] = last;
        end else begin
            i2_valid[k] = 1'b1; i2_data[k] = d; i2_keep[k] = kp; i2_user[k] = us; i2_last[k] = last;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (hdr ? i1_ready[k] : i2_ready[k]) break;
            n++;
            if (n > 200) begin
                chk("push_timeout", 32'd1, 32'd0);
                break;
            end
        end
        step();
    endtask

    task automatic wait_out(input int k, input int n);
        int t;
        t = 0;
        while (oq[k].size() < n && t < 3000) begin
            step();
            t++;
        end
        repeat (3) step();
        chk("out_count", oq[k].size(), n);
    endtask

    initial begin
        logic [10:0] exp_q [$];
        int base;
        logic [7:0] seq;

        areset = 1'b1;
        stall_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i1_valid[k] = 1'b0; i1_data[k] = '0; i1_keep[k] = 1'b0; i1_user[k] = 1'b0; i1_last[k] = 1'b0;
            i2_valid[k] = 1'b0; i2_data[k] = '0; i2_keep[k] = 1'b0; i2_user[k] = 1'b0; i2_last[k] = 1'b0;
            rdy_set[k] = 1'b1;
        end
        repeat (3) step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_o_valid", o_valid[k], 1'b0);
            chk("rst_i1_ready", i1_ready[k], 1'b0);
            chk("rst_i2_ready", i2_ready[k], 1'b0);
            chk("rst_hdr_err", hdr_err[k], 1'b0);
        end
        step();
        areset = 1'b0;
        repeat (2) step();

        // header on tlast, back-to-back output words
        base = oq[0].size();
        push(0, 1, 8'hA0, 1, 0, 0);
        push(0, 1, 8'hA1, 1, 0, 1);
        i1_valid[0] = 1'b0;
        push(0, 0, 8'hB0, 1, 0, 0);
        push(0, 0, 8'hB1, 1, 0, 0);
        push(0, 0, 8'hB2, 1, 0, 1);
        i2_valid[0] = 1'b0;
        wait_out(0, base + 5);
        exp_q = '{w(0,0,1,8'hA0), w(0,0,1,8'hA1), w(0,0,1,8'hB0), w(0,0,1,8'hB1), w(1,0,1,8'hB2)};
        for (int i = 0; i < 5; i++) begin
            chk("t1_word", oq[0][base+i], exp_q[i]);
            chk("t1_consecutive", oc[0][base+i] - oc[0][base], i);
        end

        // body valid early must wait for the header
        base = oq[0].size();
        i2_valid[0] = 1'b1; i2_data[0] = 8'hC0; i2_keep[0] = 1'b1; i2_user[0] = 1'b0; i2_last[0] = 1'b1;
        @(negedge clk);
        chk("t4_i2_ready_head", i2_ready[0], 1'b0);
        step();
        push(0, 1, 8'hD0, 1, 0, 1);
        i1_valid[0] = 1'b0;
        push(0, 0, 8'hC0, 1, 0, 1);
        i2_valid[0] = 1'b0;
        wait_out(0, base + 2);
        chk("t4_first_hdr", oq[0][base], w(0,0,1,8'hD0));
        chk("t4_then_body", oq[0][base+1], w(1,0,1,8'hC0));

        // fixed two-word header with missing tlast
        base = oq[1].size();
        push(1, 1, 8'h10, 1, 0, 0);
        push(1, 1, 8'h11, 1, 0, 0);
        i1_valid[1] = 1'b0;
        push(1, 0, 8'h20, 1, 0, 1);
        i2_valid[1] = 1'b0;
        wait_out(1, base + 3);
        chk("t2_h0", oq[1][base], w(0,0,1,8'h10));
        chk("t2_h1", oq[1][base+1], w(0,0,1,8'h11));
        chk("t2_body", oq[1][base+2], w(1,0,1,8'h20));
        chk("t2_err_count", err_cnt[1], 1);
        chk("t2_err_word", err_word[1], 8'h11);

        // one-word header per packet, sideband passthrough
        base = oq[2].size();
        push(2, 1, 8'h30, 1, 0, 1);
        i1_valid[2] = 1'b0;
        push(2, 0, 8'h31, 0, 0, 0);
        push(2, 0, 8'h32, 1, 1, 1);
        i2_valid[2] = 1'b0;
        push(2, 1, 8'h33, 1, 1, 1);
        i1_valid[2] = 1'b0;
        push(2, 0, 8'h34, 1, 0, 1);
        i2_valid[2] = 1'b0;
        wait_out(2, base + 5);
        exp_q = '{w(0,0,1,8'h30), w(0,0,0,8'h31), w(1,1,1,8'h32), w(0,1,1,8'h33), w(1,0,1,8'h34)};
        for (int i = 0; i < 5; i++) chk("t6_word", oq[2][base+i], exp_q[i]);
        chk("t6_no_err", err_cnt[2], 0);

        // random gaps and output stalls, scoreboard order
        base = oq[0].size();
        exp_q = {};
        seq = 8'h40;
        stall_mode = 1'b1;
        for (int p = 0; p < 24; p++) begin
            int hl, bl;
            hl = $urandom_range(1, 3);
            bl = $urandom_range(1, 3);
            for (int j = 0; j < hl; j++) begin
                logic kp, us;
                kp = 1'($urandom_range(0, 1));
                us = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin i1_valid[0] = 1'b0; step(); end
                push(0, 1, seq, kp, us, (j == hl - 1));
                exp_q.push_back(w(0, us, kp, seq));
                seq++;
            end
            i1_valid[0] = 1'b0;
            for (int j = 0; j < bl; j++) begin
                logic kp, us;
                kp = 1'($urandom_range(0, 1));
                us = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin i2_valid[0] = 1'b0; step(); end
                push(0, 0, seq, kp, us, (j == bl - 1));
                exp_q.push_back(w((j == bl - 1), us, kp, seq));
                seq++;
            end
            i2_valid[0] = 1'b0;
        end
        wait_out(0, base + exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < oq[0].size()) chk("t3_word", oq[0][base+i], exp_q[i]);
        end
        stall_mode = 1'b0;
        step();
        chk("t3_stall_stable", stall_bad, 0);

        // reset in the middle of a body
        push(0, 1, 8'hE0, 1, 0, 1);
        i1_valid[0] = 1'b0;
        push(0, 0, 8'hF0, 1, 0, 0);
        push(0, 0, 8'hF1, 1, 0, 0);
        areset = 1'b1;
        #1;
        chk("t5_o_valid", o_valid[0], 1'b0);
        chk("t5_i1_ready", i1_ready[0], 1'b0);
        chk("t5_i2_ready", i2_ready[0], 1'b0);
        i2_valid[0] = 1'b0;
        repeat (2) step();
        areset = 1'b0;
        repeat (2) step();
        base = oq[0].size();
        push(0, 1, 8'h50, 1, 0, 1);
        i1_valid[0] = 1'b0;
        push(0, 0, 8'h60, 1, 0, 1);
        i2_valid[0] = 1'b0;
        wait_out(0, base + 2);
        chk("t5_hdr_first", oq[0][base], w(0,0,1,8'h50));
        chk("t5_body", oq[0][base+1], w(1,0,1,8'h60));
        chk("t0_no_err", err_cnt[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
